div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 139 +++++++++++++
 tb/tb_div_iter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative 32-bit restoring divider for the EXE stage.
//
// Computes one quotient bit per clock. Signed operands are reduced to their
// magnitudes at start and the results are sign-corrected when they are
// written back. A zero divisor skips the iteration and returns all-ones as
// the quotient and the dividend as the remainder.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   divide request (ID_EXE_is_div_data)
//   is_sign    in   1 = signed DIV, 0 = unsigned DIVU (ID_EXE_is_sign_div_data)
//   cancel     in   exception/flush kill of the in-flight divide
//   src0[31:0] in   dividend
//   src1[31:0] in   divisor
//   div_stall  out  stall request to ID_EXE and the upstream stages
//   done       out  one-cycle pulse: hi_o/lo_o hold a new result
//   hi_o[31:0] out  remainder (registered)
//   lo_o[31:0] out  quotient (registered)
//
// Handshake: start is accepted in IDLE only when cancel is low. div_stall is
// high from the accepting cycle through the last RUN cycle, and done pulses
// for exactly one cycle when the result registers change. cancel always wins
// and drops div_stall in the same cycle it is raised.
// -----------------------------------------------------------------------------
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_sign,
  input  logic        cancel,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  output logic        div_stall,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] dividend;   // shifts left; quotient bits enter at the bottom
  logic [31:0] divisor;
  logic [31:0] rem;
  logic        q_sign;
  logic        r_sign;
  logic        sign_mode;

  logic [31:0] src0_abs;
  logic [31:0] src1_abs;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] next_rem;
  logic [31:0] next_quo;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  // Magnitudes; in unsigned mode the operands pass through untouched.
  // 32'h80000000 negates to itself, which is the correct magnitude when
  // treated as unsigned.
  assign src0_abs = (is_sign && src0[31]) ? (~src0 + 32'd1) : src0;
  assign src1_abs = (is_sign && src1[31]) ? (~src1 + 32'd1) : src1;

  // One restoring step on a 33-bit partial remainder. Since rem < divisor,
  // shifted - divisor is always below 2^32 when it is non-negative, so bit 32
  // of the 33-bit difference is exactly the borrow.
  assign shifted  = {rem, dividend[31]};
  assign diff     = shifted - {1'b0, divisor};
  assign fits     = ~diff[32];
  assign next_rem = fits ? diff[31:0] : shifted[31:0];
  assign next_quo = {dividend[30:0], fits};

  assign quo_final = (sign_mode && q_sign) ? (~next_quo + 32'd1) : next_quo;
  assign rem_final = (sign_mode && r_sign) ? (~next_rem + 32'd1) : next_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 5'd0;
      dividend  <= 32'd0;
      divisor   <= 32'd0;
      rem       <= 32'd0;
      q_sign    <= 1'b0;
      r_sign    <= 1'b0;
      sign_mode <= 1'b0;
      hi_o      <= 32'd0;
      lo_o      <= 32'd0;
    end else if (cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_mode <= is_sign;
            q_sign    <= src0[31] ^ src1[31];
            r_sign    <= src0[31];
            dividend  <= src0_abs;
            divisor   <= src1_abs;
            rem       <= 32'd0;
            count     <= 5'd0;
            if (src1 == 32'd0) begin
              lo_o  <= 32'hFFFF_FFFF;
              hi_o  <= src0;
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          dividend <= next_quo;
          rem      <= next_rem;
          count    <= count + 5'd1;
          if (count == 5'd31) begin
            lo_o  <= quo_final;
            hi_o  <= rem_final;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign done      = (state == DONE);
  assign div_stall = ~cancel & (((state == IDLE) & start) | (state == RUN));

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter -- directed plus random checks for div_iter.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled on the falling edge. Expected {hi, lo} pairs are queued when a
// divide is launched and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_sign;
  logic        cancel;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        div_stall;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int          total  = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  string       cur_test = "reset";

  div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_sign   (is_sign),
    .cancel    (cancel),
    .src0      (src0),
    .src1      (src1),
    .div_stall (div_stall),
    .done      (done),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model for random operands, built on the language's own operators.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // scoreboard: compare on every done pulse
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check({cur_test, "_unexpected_done"}, {31'd0, done}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check({cur_test, "_hi"}, hi_o, mon_exp[63:32]);
        check({cur_test, "_lo"}, lo_o, mon_exp[31:0]);
      end
    end
  end

  // Called 1 unit after a rising edge; returns 1 unit after a rising edge.
  // The start cycle is cycle 0. Operands are scrambled after cycle 0.
  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] exp_q_val,
                        input logic [31:0] exp_r_val, input int exp_lat);
    int lat;
    int stall_cnt;
    cur_test  = name;
    src0      = a;
    src1      = b;
    is_sign   = sgn;
    cancel    = 1'b0;
    start     = 1'b1;
    exp_q.push_back({exp_r_val, exp_q_val});
    lat       = -1;
    stall_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_stall) stall_cnt++;
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
      start   = 1'b0;
      src0    = $urandom;
      src1    = $urandom;
      is_sign = 1'($urandom_range(0, 1));
    end
    check({name, "_done_cycle"}, 32'(lat), 32'(exp_lat));
    check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    if (lat >= 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          dn;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] rq;
    logic [31:0] rr;

    // reset
    rst     = 1'b1;
    start   = 1'b0;
    cancel  = 1'b0;
    is_sign = 1'b0;
    src0    = 32'd0;
    src1    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, div_stall}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    @(posedge clk);
    #1;

    // directed divides
    do_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    do_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 33);
    do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
    do_div("s_min_2", 32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 33);
    do_div("div0", 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1);
    do_div("u100_7b", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);

    // cancel in cycle 10 of a divide, then 9/3 starting in cycle 11
    cur_test = "cancel";
    src0     = 32'd50000;
    src1     = 32'd7;
    is_sign  = 1'b0;
    start    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_stall", {31'd0, div_stall}, 32'd0);
    check("cancel_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_hold_hi", hi_o, 32'd2);
    check("cancel_hold_lo", lo_o, 32'd14);
    check("cancel_after_done", {31'd0, done}, 32'd0);
    do_div("div9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

    // reset in cycle 5 of a divide
    cur_test = "rst_mid";
    src0     = 32'd1000;
    src1     = 32'd3;
    is_sign  = 1'b0;
    start    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_hi", hi_o, 32'd0);
    check("rst_mid_lo", lo_o, 32'd0);
    @(negedge clk);
    check("rst_mid_stall", {31'd0, div_stall}, 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rst_mid_no_done", 32'(dn), 32'd0);
    @(posedge clk);
    #1;

    // start and cancel together: nothing accepted
    cur_test = "start_cancel";
    src0     = 32'd20;
    src1     = 32'd4;
    start    = 1'b1;
    cancel   = 1'b1;
    @(negedge clk);
    check("start_cancel_stall", {31'd0, div_stall}, 32'd0);
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    @(negedge clk);
    check("start_cancel_idle_stall", {31'd0, div_stall}, 32'd0);
    check("start_cancel_done", {31'd0, done}, 32'd0);
    check("start_cancel_lo", lo_o, 32'd0);
    @(posedge clk);
    #1;

    // random divides against the model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd1;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rq, rr);
      do_div("rand", ra, rb, rs, rq, rr, 33);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
